alu_exec: RTL and testbench



---
 rtl/alu_exec.sv | 178 +++++++++++++++++
 tb/tb_alu_exec.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- single-issue 32-bit ALU execution unit with a result handshake.
//
// Accepts one operation at a time (valid_i/ready_o), computes it, and holds
// the result on data_o/zero_o with valid_o high until downstream takes it
// (valid_o/ready_i). Multiply is an iterative shift-add (32 cycles) unless the
// ALU_EXEC_FAST_MUL_EN macro is defined, in which case it is a single-cycle
// combinational multiply with the same latency as every other operation.
//
// Handshake semantics: a transfer happens on a rising clk_i edge where the
// sender's valid and the receiver's ready are both 1. The request side is
// sampled only on that edge. valid_o stays high and data_o/zero_o stay stable
// until the edge where ready_i is also 1.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   synchronous active-low reset
//   valid_i      in   1   request valid
//   ready_o      out  1   unit idle, can accept a request
//   control_i    in   3   0 and, 1 xor, 2 sll, 3 add, 4 sub, 5 mul, 6 sub, 7 srai
//   data1_i      in   32  operand A
//   data2_i      in   32  operand B (shift amount = data2_i[4:0])
//   valid_o      out  1   result valid
//   ready_i      in   1   downstream accepts result
//   data_o       out  32  result
//   zero_o       out  1   result equals zero
//   state_dbg_o  out  2   current FSM state (0 IDLE, 1 MUL, 2 DONE)
//
// Build option: ALU_EXEC_FAST_MUL_EN -- single-cycle multiply, MUL state unused.
// -----------------------------------------------------------------------------
module alu_exec (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  control_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        zero_o,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL = 3'd5;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_zero, w_zero_nxt;
  logic [31:0] w_alu;

`ifdef ALU_EXEC_FAST_MUL_EN
  logic [31:0] w_prod;
  assign w_prod = data1_i * data2_i;  // low half only; sign does not matter
`else
  // Shift-add multiplier: multiplicand moves left, multiplier moves right,
  // one multiplier bit consumed per MUL cycle.
  logic [31:0] r_mcand, w_mcand_nxt;
  logic [31:0] r_mplier, w_mplier_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [31:0] w_acc_add;
  assign w_acc_add = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
`endif

  // Single-cycle datapath for every code; code 6 is the branch-compare alias
  // of subtract and must produce exactly the same value.
  always_comb begin
    w_alu = 32'd0;
    case (control_i)
      3'd0: w_alu = data1_i & data2_i;
      3'd1: w_alu = data1_i ^ data2_i;
      3'd2: w_alu = data1_i << data2_i[4:0];
      3'd3: w_alu = data1_i + data2_i;
      3'd4: w_alu = data1_i - data2_i;
`ifdef ALU_EXEC_FAST_MUL_EN
      3'd5: w_alu = w_prod;
`else
      3'd5: w_alu = 32'd0;  // handled by the iterative path
`endif
      3'd6: w_alu = data1_i - data2_i;
      3'd7: w_alu = $unsigned($signed(data1_i) >>> data2_i[4:0]);
      default: w_alu = 32'd0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_zero_nxt   = r_zero;
`ifndef ALU_EXEC_FAST_MUL_EN
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
`ifdef ALU_EXEC_FAST_MUL_EN
          w_state_nxt = S_DONE;
          w_data_nxt  = w_alu;
          w_zero_nxt  = (w_alu == 32'd0);
`else
          if (control_i == OP_MUL) begin
            w_state_nxt  = S_MUL;
            w_mcand_nxt  = data1_i;
            w_mplier_nxt = data2_i;
            w_acc_nxt    = 32'd0;
            w_cnt_nxt    = 5'd0;
          end else begin
            w_state_nxt = S_DONE;
            w_data_nxt  = w_alu;
            w_zero_nxt  = (w_alu == 32'd0);
          end
`endif
        end
      end
      S_MUL: begin
`ifdef ALU_EXEC_FAST_MUL_EN
        w_state_nxt = S_IDLE;
`else
        w_acc_nxt    = w_acc_add;
        w_mcand_nxt  = {r_mcand[30:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[31:1]};
        w_cnt_nxt    = r_cnt + 5'd1;  // wraps back to 0 after the last bit
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
          w_data_nxt  = w_acc_add;
          w_zero_nxt  = (w_acc_add == 32'd0);
        end
`endif
      end
      S_DONE: begin
        if (ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_data   <= 32'd0;
      r_zero   <= 1'b1;
`ifndef ALU_EXEC_FAST_MUL_EN
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 5'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_zero   <= w_zero_nxt;
`ifndef ALU_EXEC_FAST_MUL_EN
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
`endif
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign data_o      = r_data;
  assign zero_o      = r_zero;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  control_i = 3'd0;
  logic [31:0] data1_i = 32'd0;
  logic [31:0] data2_i = 32'd0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        zero_o;
  logic [1:0]  state_dbg_o;

  always #5 clk_i = ~clk_i;

  alu_exec dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .control_i   (control_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .zero_o      (zero_o),
    .state_dbg_o (state_dbg_o)
  );

`ifdef ALU_EXEC_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];  // {zero, data}
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Independent reference for randomized operations.
  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a ^ b;
      3'd2: r = a << b[4:0];
      3'd3: r = a + b;
      3'd5: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd7: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = a - b;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, scrambles the inputs after the accept edge, pulses
  // valid_i while busy, measures latency, checks the held result for `hold`
  // cycles with ready_i low, then completes the handshake.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input int lat, input int hold);
    int n;
    logic [32:0] e;
    @(negedge clk_i);
    check({tag, "_ready_idle"}, {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; control_i = c; data1_i = a; data2_i = b;
    exp_q.push_back({(exp_data == 32'd0), exp_data});
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    control_i = 3'($urandom_range(0, 7)); data1_i = $urandom; data2_i = $urandom;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (!valid_o) begin
        if (n % 8 == 1) check({tag, "_busy_ready"}, {31'd0, ready_o}, 32'd0);
        valid_i = n[0];
      end
    end while (!valid_o && n < 100);
    valid_i = 1'b0;
    check({tag, "_latency"}, n, lat);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      e = 33'd0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_data"}, data_o, e[31:0]);
    check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_hold_data"}, data_o, e[31:0]);
      check({tag, "_hold_zero"}, {31'd0, zero_o}, {31'd0, e[32]});
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, "_post_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, ready_o}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0]  rc;
    logic [31:0] ra, rb;

    // Reset with a simultaneous request: reset must win.
    rst_i = 1'b0; valid_i = 1'b1; control_i = 3'd3; data1_i = 32'd7; data2_i = 32'd9;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_zero", {31'd0, zero_o}, 32'd1);
    check("rst_state", {30'd0, state_dbg_o}, 32'd0);
    valid_i = 1'b0; ready_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid2", {31'd0, valid_o}, 32'd0);

    // Directed cases with hand-derived results.
    run_op("add53",  3'd3, 32'h5,        32'h3,        32'h8,        1, 0);
    run_op("cmp_eq", 3'd6, 32'h1234,     32'h1234,     32'h0,        1, 1);
    run_op("srai",   3'd7, 32'h80000000, 32'd4,        32'hF8000000, 1, 0);
    run_op("sll37",  3'd2, 32'h1,        32'd37,       32'h20,       1, 0);
    run_op("mul",    3'd5, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD, MUL_LAT, 0);
    run_op("addwrap",3'd3, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 5);
    run_op("and",    3'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1, 0);
    run_op("xor",    3'd1, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1, 0);
    run_op("sub_neg",3'd4, 32'h3,        32'h5,        32'hFFFFFFFE, 1, 0);
    run_op("sub6",   3'd6, 32'h10,       32'h1,        32'hF,        1, 0);
    run_op("srai_p", 3'd7, 32'h7FFFFFF0, 32'hFFFFFFE4, 32'h07FFFFFF, 1, 0);
    run_op("mul_big",3'd5, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, MUL_LAT, 2);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk_i);
    valid_i = 1'b1; control_i = 3'd5; data1_i = 32'd6; data2_i = 32'd7;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
`ifndef ALU_EXEC_FAST_MUL_EN
    check("abort_in_mul", {30'd0, state_dbg_o}, 32'd1);
`endif
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_data", data_o, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) check("abort_no_pulse", {31'd0, valid_o}, 32'd0);
    end
    run_op("add22",  3'd3, 32'h2, 32'h2, 32'h4, 1, 0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 8; k++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k == 3) ? ra : $urandom;
      run_op("rand", rc, ra, rb, model(rc, ra, rb), (rc == 3'd5) ? MUL_LAT : 1,
             int'($urandom_range(0, 2)));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
